// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit frame sequencer. Accepts a byte from the
//               upstream handshake and walks the TX mux through start,
//               data, optional parity and stop bits, one bit per clk.
//               Drives the serializer load/shift strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_data_valid,
  input  logic       i_par_en,
  output logic [2:0] o_mux_sel,
  output logic       o_ser_load,
  output logic       o_ser_en,
  output logic       o_busy,
  output logic       o_frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [2:0]       c_SEL_START  = 3'b000;
  localparam logic [2:0]       c_SEL_STOP   = 3'b001;
  localparam logic [2:0]       c_SEL_DATA   = 3'b010;
  localparam logic [2:0]       c_SEL_PARITY = 3'b011;
  localparam logic [2:0]       c_SEL_IDLE   = 3'b100;
  localparam logic [CNT_W-1:0] c_LAST_BIT   = CNT_W'(DATA_WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_par_en_q;
  logic [2:0]       r_mux_sel;
  logic             r_ser_en;
  logic             r_busy;
  logic             r_frame_done;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_next_par;
  logic             w_accept;

  // A new byte can only be taken while idle or in the final (stop) bit,
  // which gives back-to-back frames with no idle gap. Gated by reset so
  // no load strobe escapes while the block is held in reset.
  assign w_accept   = rst_n & i_data_valid &
                      ((r_state == S_IDLE) | (r_state == S_STOP));
  assign o_ser_load = w_accept;

  // Mux select for a given state; anything unexpected reads as idle.
  function automatic logic [2:0] f_sel(input state_t s);
    case (s)
      S_START:  f_sel = c_SEL_START;
      S_DATA:   f_sel = c_SEL_DATA;
      S_PARITY: f_sel = c_SEL_PARITY;
      S_STOP:   f_sel = c_SEL_STOP;
      default:  f_sel = c_SEL_IDLE;
    endcase
  endfunction

  // Next-state, bit-counter and parity-capture logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_bit_cnt;
    w_next_par   = r_par_en_q;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_START;
          w_next_par   = i_par_en;
        end
      end
      S_START: begin
        w_next_state = S_DATA;
        w_next_cnt   = '0;
      end
      S_DATA: begin
        if (r_bit_cnt == c_LAST_BIT) begin
          w_next_cnt   = '0;
          w_next_state = r_par_en_q ? S_PARITY : S_STOP;
        end else begin
          w_next_cnt   = r_bit_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        w_next_state = S_STOP;
      end
      S_STOP: begin
        if (w_accept) begin
          w_next_state = S_START;
          w_next_par   = i_par_en;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // State register; Moore outputs are registered from the next state so
  // they always line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_par_en_q   <= 1'b0;
      r_mux_sel    <= c_SEL_IDLE;
      r_ser_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_bit_cnt    <= w_next_cnt;
      r_par_en_q   <= w_next_par;
      r_mux_sel    <= f_sel(w_next_state);
      r_ser_en     <= (w_next_state == S_DATA);
      r_busy       <= (w_next_state == S_START)  || (w_next_state == S_DATA) ||
                      (w_next_state == S_PARITY) || (w_next_state == S_STOP);
      r_frame_done <= (w_next_state == S_STOP);
    end
  end

  assign o_mux_sel    = r_mux_sel;
  assign o_ser_en     = r_ser_en;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Scoreboard bench for uart_tx_ctrl. A frame-level model
//               queues the per-cycle output pattern of each accepted frame;
//               a monitor compares every cycle against that expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  typedef struct packed {
    logic [2:0] mux;
    logic       en;
    logic       busy;
    logic       done;
    logic       load;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv    = 1'b0;
  logic       pe    = 1'b0;
  logic [2:0] mux_sel;
  logic       ser_load, ser_en, busy, frame_done;

  exp_t model_q[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_cyc = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data_valid(dv),
    .i_par_en    (pe),
    .o_mux_sel   (mux_sel),
    .o_ser_load  (ser_load),
    .o_ser_en    (ser_en),
    .o_busy      (busy),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] m, input logic e,
                              input logic b, input logic d);
    exp_t x;
    x.mux = m; x.en = e; x.busy = b; x.done = d; x.load = 1'b0;
    return x;
  endfunction

  // One accepted frame: start, DW data bits, optional parity, stop.
  task automatic push_frame(input logic par);
    model_q.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < DW; i++) model_q.push_back(mk(3'b010, 1'b1, 1'b1, 1'b0));
    if (par) model_q.push_back(mk(3'b011, 1'b0, 1'b1, 1'b0));
    model_q.push_back(mk(3'b001, 1'b0, 1'b1, 1'b1));
  endtask

  // Drive one clock's inputs and post this cycle's expectation.
  // A byte is taken when the cycle is idle or the last cycle of a frame,
  // i.e. when nothing of the current frame remains queued after it.
  task automatic cycle(input logic v, input logic p, input logic r);
    exp_t cur;
    @(posedge clk); #1;
    dv = v; pe = p; rst_n = !r;
    if (r) begin
      model_q.delete();
      cur = mk(3'b100, 1'b0, 1'b0, 1'b0);
    end else begin
      cur = (model_q.size() != 0) ? model_q.pop_front() : mk(3'b100, 1'b0, 1'b0, 1'b0);
      if (v && model_q.size() == 0) begin
        cur.load = 1'b1;
        push_frame(p);
      end
    end
    sb_q.push_back(cur);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the scoreboard.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        a.mux = mux_sel; a.en = ser_en; a.busy = busy; a.done = frame_done; a.load = ser_load;
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle%0d outputs: got mux=%b en=%b busy=%b done=%b load=%b, want mux=%b en=%b busy=%b done=%b load=%b",
                   n_cyc, a.mux, a.en, a.busy, a.done, a.load, e.mux, e.en, e.busy, e.done, e.load);
        end
        n_cyc++;
      end
    end
  end

  initial begin
    // Reset, then idle with no valid.
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    // Single frame, no parity.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    // Parity frame, par_en dropped mid-frame.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    // Continuous valid: back-to-back frames.
    repeat (35) cycle(1'b1, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    // Valid pulses during DATA bit 3 and during PARITY are ignored.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    // Reset in DATA at bit 4, then a fresh frame.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++)
      cycle(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 149) == 0));
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    @(posedge clk); #6;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. Owns the TX output mux select, and the serializer enable and load strobes. Each accepted byte is emitted as one frame on successive clocks: start bit, DATA_WIDTH data bits, an optional parity bit, then a stop bit. Sits between the TX-side data handshake and the serializer / parity calculator / TX mux, all clocked on the TX bit clock.

Parameters:
DATA_WIDTH, 8, data bits per frame (range 5..9).
CNT_W, $clog2(DATA_WIDTH), bit counter width (derived, not overridden).

Ports:
clk  in  1  TX bit clock; one bit period per cycle.
rst  in  1  asynchronous, active-low reset.
data_valid  in  1  new byte available for transmission.
par_en  in  1  parity bit enable; sampled only when a frame is accepted.
mux_sel  out  3  TX mux select: 000 start, 001 stop, 010 serial data, 011 parity, 100 idle.
ser_load  out  1  serializer parallel-load strobe; combinational, one cycle.
ser_en  out  1  serializer shift enable.
busy  out  1  frame in progress.
frame_done  out  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset (async, rst=0): state=IDLE, bit_cnt=0, par_en_q=0. Outputs: mux_sel=100, ser_en=0, ser_load=0, busy=0, frame_done=0.
- All outputs except ser_load are Moore-decoded from the state register.
- The TX mux registers its output, so the line lags mux_sel by one clk. The controller does not compensate for this.
- States and outputs:
  - IDLE: mux_sel=100, busy=0.
    - If data_valid=1: ser_load=1 in this cycle, capture par_en into par_en_q, next state START.
    - Otherwise remain in IDLE.
  - START: mux_sel=000, busy=1, exactly 1 cycle. Clear bit_cnt. Next state DATA.
  - DATA: mux_sel=010, ser_en=1, busy=1, exactly DATA_WIDTH cycles.
    - bit_cnt increments each cycle.
    - When bit_cnt==DATA_WIDTH-1: go to PARITY if par_en_q=1, else STOP. bit_cnt returns to 0.
  - PARITY: mux_sel=011, busy=1, 1 cycle. Next state STOP.
  - STOP: mux_sel=001, busy=1, frame_done=1, 1 cycle.
    - If data_valid=1: ser_load=1, capture par_en, next state START (back-to-back frame, no idle gap).
    - Otherwise next state IDLE.
- data_valid is ignored in START, DATA and PARITY. No ser_load is issued and no state is lost. The upstream block holds data_valid until it sees ser_load.
- Changes to par_en after acceptance have no effect on the current frame.
- Frame length: 1 + DATA_WIDTH + par_en_q + 1 cycles, i.e. 10 or 11 cycles at DATA_WIDTH=8.
- ser_en is never high outside DATA. ser_load and ser_en are never high in the same cycle.
- Reset asserted mid-frame: immediate return to IDLE and all reset values. The partial frame is abandoned. The first frame after reset release starts from IDLE.
- Unreachable state encodings recover to IDLE on the next clk.

Test Plan:
- Reset release, data_valid=0 for 5 cycles -> mux_sel=100, busy=0, ser_en=0, ser_load=0 throughout.
- DATA_WIDTH=8, par_en=0, single data_valid pulse in IDLE -> ser_load=1 in that cycle. Then mux_sel sequence is 000, 010×8, 001, then 100. ser_en high for exactly 8 cycles. frame_done high 1 cycle. busy high for 10 cycles.
- par_en=1 at accept, then par_en toggled to 0 during DATA -> sequence 000, 010×8, 011, 001. busy high for 11 cycles.
- data_valid held high continuously, par_en=0 -> ser_load fires in the IDLE cycle and then in every STOP cycle. Frames repeat with period 10 and mux_sel never returns to 100.
- data_valid pulsed during DATA cycle 3 and during PARITY -> no ser_load, and the sequence is unchanged.
- rst asserted during DATA at bit_cnt=4 -> same-cycle mux_sel=100, ser_en=0, busy=0. After release with data_valid=1, a full 10-cycle frame starts from START.
